// File: rtl/dpram_port_arbiter.sv
// Single-port controller for the 1024x16 block RAM: optional post-reset clear sweep,
// then round-robin sharing of the port between two requesters with one-cycle read return.
module dpram_port_arbiter #(
  parameter int                 ADDR_W         = 10,
  parameter int                 DATA_W         = 16,
  parameter int                 DEPTH          = 1024,
  parameter bit                 CLEAR_ON_RESET = 1'b1,
  parameter logic [DATA_W-1:0]  INIT_VALUE     = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              init_done,
  output logic              ram_en,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            r_state;
  state_t            w_nextState;
  logic [ADDR_W-1:0] r_count;
  logic [ADDR_W-1:0] r_lastAddr;
  logic              r_prio;
  logic              r_rvalid0;
  logic              r_rvalid1;
  logic              w_sweepEnd;

  assign w_sweepEnd = (r_count == LAST_ADDR);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= CLEAR_ON_RESET ? ST_INIT : ST_RUN;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    if (r_state == ST_INIT && w_sweepEnd) begin
      w_nextState = ST_RUN;
    end
  end

  // Reset overrides everything; r_prio only matters when both requesters are waiting.
  always_comb begin
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    init_done = 1'b0;
    ram_en    = 1'b0;
    ram_addr  = r_lastAddr;
    ram_wdata = '0;
    if (rst_n) begin
      if (r_state == ST_INIT) begin
        ram_en    = 1'b1;
        ram_addr  = r_count;
        ram_wdata = INIT_VALUE;
      end else begin
        init_done = 1'b1;
        if (req0 && (!req1 || !r_prio)) begin
          gnt0      = 1'b1;
          ram_en    = we0;
          ram_addr  = addr0;
          ram_wdata = wdata0;
        end else if (req1) begin
          gnt1      = 1'b1;
          ram_en    = we1;
          ram_addr  = addr1;
          ram_wdata = wdata1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count    <= '0;
      r_lastAddr <= '0;
      r_prio     <= 1'b0;
      r_rvalid0  <= 1'b0;
      r_rvalid1  <= 1'b0;
    end else begin
      if (r_state == ST_INIT && !w_sweepEnd) begin
        r_count <= r_count + 1'b1;
      end
      if (gnt0) begin
        r_prio     <= 1'b1;
        r_lastAddr <= addr0;
      end else if (gnt1) begin
        r_prio     <= 1'b0;
        r_lastAddr <= addr1;
      end
      r_rvalid0 <= gnt0 && !we0;
      r_rvalid1 <= gnt1 && !we1;
    end
  end

  assign rvalid0 = r_rvalid0;
  assign rvalid1 = r_rvalid1;
  assign rdata0  = r_rvalid0 ? ram_rdata : '0;
  assign rdata1  = r_rvalid1 ? ram_rdata : '0;

endmodule

// File: tb/tb_dpram_port_arbiter.sv
// Directed bench for dpram_port_arbiter: one instance with the clear sweep, one without,
// each attached to a small write-first registered RAM model.
module tb_dpram_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance A: CLEAR_ON_RESET = 1
  logic        rstA = 1'b0;
  logic        req0A = 1'b0, req1A = 1'b0, we0A = 1'b0, we1A = 1'b0;
  logic [9:0]  addr0A = '0, addr1A = '0;
  logic [15:0] wdata0A = '0, wdata1A = '0;
  logic        gnt0A, gnt1A, rvalid0A, rvalid1A, initDoneA, ramEnA;
  logic [15:0] rdata0A, rdata1A, ramWdataA;
  logic [15:0] ramRdataA;
  logic [9:0]  ramAddrA;

  // Instance B: CLEAR_ON_RESET = 0
  logic        rstB = 1'b0;
  logic        req1B = 1'b0;
  logic [9:0]  addr1B = '0;
  logic        gnt0B, gnt1B, rvalid0B, rvalid1B, initDoneB, ramEnB;
  logic [15:0] rdata0B, rdata1B, ramWdataB;
  logic [15:0] ramRdataB;
  logic [9:0]  ramAddrB;

  dpram_port_arbiter #(.CLEAR_ON_RESET(1'b1)) dutA (
    .clk(clk), .rst_n(rstA),
    .req0(req0A), .req1(req1A), .we0(we0A), .we1(we1A),
    .addr0(addr0A), .addr1(addr1A), .wdata0(wdata0A), .wdata1(wdata1A),
    .gnt0(gnt0A), .gnt1(gnt1A), .rvalid0(rvalid0A), .rvalid1(rvalid1A),
    .rdata0(rdata0A), .rdata1(rdata1A), .init_done(initDoneA),
    .ram_en(ramEnA), .ram_addr(ramAddrA), .ram_wdata(ramWdataA), .ram_rdata(ramRdataA)
  );

  dpram_port_arbiter #(.CLEAR_ON_RESET(1'b0)) dutB (
    .clk(clk), .rst_n(rstB),
    .req0(1'b0), .req1(req1B), .we0(1'b0), .we1(1'b0),
    .addr0(10'h000), .addr1(addr1B), .wdata0(16'h0000), .wdata1(16'h0000),
    .gnt0(gnt0B), .gnt1(gnt1B), .rvalid0(rvalid0B), .rvalid1(rvalid1B),
    .rdata0(rdata0B), .rdata1(rdata1B), .init_done(initDoneB),
    .ram_en(ramEnB), .ram_addr(ramAddrB), .ram_wdata(ramWdataB), .ram_rdata(ramRdataB)
  );

  // RAM contents stored XORed with an address pattern so unwritten words read as pattern
  function automatic logic [15:0] pat(input logic [9:0] a);
    return {6'b0, a} ^ 16'h5A5A;
  endfunction

  logic [15:0] memA [1024] = '{default: 16'h0000};
  logic [15:0] memB [1024] = '{default: 16'h0000};

  always @(posedge clk) begin
    if (ramEnA) memA[ramAddrA] <= ramWdataA ^ pat(ramAddrA);
    ramRdataA <= ramEnA ? ramWdataA : (memA[ramAddrA] ^ pat(ramAddrA));
    if (ramEnB) memB[ramAddrB] <= ramWdataB ^ pat(ramAddrB);
    ramRdataB <= ramEnB ? ramWdataB : (memB[ramAddrB] ^ pat(ramAddrB));
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%h expected=%h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic r0, input logic w0, input logic [9:0] a0, input logic [15:0] d0,
                               input logic r1, input logic w1, input logic [9:0] a1, input logic [15:0] d1);
    req0A = r0; we0A = w0; addr0A = a0; wdata0A = d0;
    req1A = r1; we1A = w1; addr1A = a1; wdata1A = d1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Instance B: no sweep, immediate grant after reset
    req1B = 1'b1; addr1B = 10'h3FF;
    tick(); tick();
    @(negedge clk);
    checkOutput("B_rst_gnt_en_done", {gnt1B, ramEnB, initDoneB, rvalid1B}, 4'b0000);
    tick();
    rstB = 1'b1;
    @(negedge clk);
    checkOutput("B_first_gnt_done_en", {gnt1B, initDoneB, ramEnB}, 3'b110);
    tick();
    req1B = 1'b0;
    @(negedge clk);
    checkOutput("B_rvalid_en", {rvalid1B, ramEnB, gnt1B}, 3'b100);
    checkOutput("B_rdata", rdata1B, 16'h59A5);

    // Instance A: reset with req0 already pending
    applyStimulus(1'b1, 1'b0, 10'h000, 16'h0000, 1'b0, 1'b0, 10'h000, 16'h0000);
    @(negedge clk);
    checkOutput("A_rst_outputs", {gnt0A, gnt1A, ramEnA, initDoneA, rvalid0A, rvalid1A}, 6'b000000);
    tick();
    rstA = 1'b1;
    for (int i = 0; i < 300; i++) tick();
    @(negedge clk);
    checkOutput("A_sweep_at_300", ramAddrA, 32'd300);
    rstA = 1'b0;
    #1;
    checkOutput("A_rst_in_init_forced", {ramEnA, gnt0A, initDoneA}, 3'b000);
    tick();
    rstA = 1'b1;
    for (int i = 0; i < 1024; i++) begin
      @(negedge clk);
      checkOutput("A_sweep", {ramEnA, gnt0A, initDoneA, ramWdataA, ramAddrA}, {1'b1, 1'b0, 1'b0, 16'h0000, 10'(i)});
      tick();
    end
    @(negedge clk);
    checkOutput("A_run_first", {initDoneA, gnt0A, gnt1A, ramEnA}, 4'b1100);
    checkOutput("A_run_first_addr", ramAddrA, 32'h000);

    tick();
    applyStimulus(1'b1, 1'b1, 10'h005, 16'hBEEF, 1'b0, 1'b0, 10'h000, 16'h0000);
    @(negedge clk);
    checkOutput("A_swept_read", {rvalid0A, rdata0A}, {1'b1, 16'h0000});
    checkOutput("A_wr_port", {gnt0A, ramEnA, ramAddrA, ramWdataA}, {1'b1, 1'b1, 10'h005, 16'hBEEF});

    tick();
    applyStimulus(1'b1, 1'b0, 10'h005, 16'h0000, 1'b0, 1'b0, 10'h000, 16'h0000);
    @(negedge clk);
    checkOutput("A_rd_gnt_no_rvalid", {gnt0A, ramEnA, rvalid0A}, 3'b100);

    tick();
    applyStimulus(1'b0, 1'b0, 10'h000, 16'h0000, 1'b0, 1'b0, 10'h000, 16'h0000);
    @(negedge clk);
    checkOutput("A_rd_back", {rvalid0A, rdata0A}, {1'b1, 16'hBEEF});
    checkOutput("A_idle_port", {gnt0A, gnt1A, ramEnA, ramAddrA, ramWdataA}, {3'b000, 10'h005, 16'h0000});

    for (int k = 0; k < 3; k++) begin
      tick();
      applyStimulus(1'b0, 1'b0, 10'h000, 16'h0000, 1'b1, 1'b1, 10'(16 + k), 16'(16'h1111 * (k + 1)));
      @(negedge clk);
      checkOutput("A_req1_only", {gnt0A, gnt1A, ramEnA, rvalid1A}, 4'b0110);
    end
    tick();
    applyStimulus(1'b1, 1'b1, 10'h020, 16'hAAAA, 1'b1, 1'b1, 10'h013, 16'h4444);
    @(negedge clk);
    checkOutput("A_both_after_req1", {gnt0A, gnt1A, ramAddrA}, {2'b10, 10'h020});
    tick();
    applyStimulus(1'b0, 1'b0, 10'h000, 16'h0000, 1'b1, 1'b1, 10'h013, 16'h4444);
    @(negedge clk);
    checkOutput("A_req1_after_req0", {gnt0A, gnt1A, ramAddrA}, {2'b01, 10'h013});

    for (int k = 0; k < 5; k++) begin
      logic expG0, expG1, expV0, expV1;
      tick();
      if (k < 4) applyStimulus(1'b1, 1'b0, 10'h020, 16'h0000, 1'b1, 1'b0, 10'h010, 16'h0000);
      else       applyStimulus(1'b0, 1'b0, 10'h000, 16'h0000, 1'b0, 1'b0, 10'h000, 16'h0000);
      expG0 = (k < 4) && (k % 2 == 0);
      expG1 = (k < 4) && (k % 2 == 1);
      expV0 = (k > 0) && ((k - 1) % 2 == 0);
      expV1 = (k > 0) && ((k - 1) % 2 == 1);
      @(negedge clk);
      checkOutput("A_rr_flags", {gnt0A, gnt1A, rvalid0A, rvalid1A}, {expG0, expG1, expV0, expV1});
      checkOutput("A_rr_rdata0", rdata0A, expV0 ? 16'hAAAA : 16'h0000);
      checkOutput("A_rr_rdata1", rdata1A, expV1 ? 16'h1111 : 16'h0000);
    end

    tick();
    applyStimulus(1'b1, 1'b0, 10'h013, 16'h0000, 1'b0, 1'b0, 10'h000, 16'h0000);
    @(negedge clk);
    checkOutput("A_pre_rst_gnt", gnt0A, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 10'h000, 16'h0000, 1'b0, 1'b0, 10'h000, 16'h0000);
    rstA = 1'b0;
    @(negedge clk);
    checkOutput("A_inflight_rdata", {rvalid0A, rdata0A}, {1'b1, 16'h4444});
    tick();
    @(negedge clk);
    checkOutput("A_rvalid_dropped", {rvalid0A, initDoneA, ramEnA}, 3'b000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
